// File: rtl/bus_pkg.sv
// Shared types for the lab bus datapath and its command sequencer.
//   op_e    : command opcodes (LOAD, MOVE, SWAP, CLEAR)
//   sel_e   : bus source / destination register encoding (IMM, U2, U3, U4)
//   state_e : sequencer FSM states
//   step_t  : one expanded bus transfer {source select, destination, last step}
// The datapath reuses sel_e for its bus mux.
package bus_pkg;

  typedef enum logic [1:0] {
    OpLoad  = 2'b00,
    OpMove  = 2'b01,
    OpSwap  = 2'b10,
    OpClear = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SelImm = 2'b00,
    SelU2  = 2'b01,
    SelU3  = 2'b10,
    SelU4  = 2'b11
  } sel_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StErr
  } state_e;

  typedef struct packed {
    sel_e sel;
    sel_e dst;
    logic last;
  } step_t;

  // Expand (op, src, dst) into the transfer for a given step index.
  // SWAP uses U4 as the temporary: src->U4, dst->src, U4->dst.
  function automatic step_t step_map(op_e op, sel_e src, sel_e dst, logic [1:0] step);
    step_t s;
    s.sel  = SelImm;
    s.dst  = dst;
    s.last = 1'b1;
    unique case (op)
      OpLoad, OpClear: s.sel = SelImm;
      OpMove:          s.sel = src;
      OpSwap: begin
        case (step)
          2'd0: begin
            s.sel  = src;
            s.dst  = SelU4;
            s.last = 1'b0;
          end
          2'd1: begin
            s.sel  = dst;
            s.dst  = src;
            s.last = 1'b0;
          end
          default: begin
            s.sel  = SelU4;
            s.dst  = dst;
            s.last = 1'b1;
          end
        endcase
      end
      default: s.sel = SelImm;
    endcase
    return s;
  endfunction

  // A command is illegal if it targets no register, or if a SWAP is not a
  // distinct pair drawn from {U2, U3} (U4 is reserved as the temporary).
  function automatic logic cmd_legal(op_e op, sel_e src, sel_e dst);
    logic ok;
    ok = (dst != SelImm);
    if (op == OpSwap) begin
      ok = ok && (src inside {SelU2, SelU3}) && (dst inside {SelU2, SelU3}) && (src != dst);
    end
    return ok;
  endfunction

  // Immediate value presented on the bus; zero whenever the bus is not
  // sourced from the immediate, and always zero for CLEAR.
  function automatic logic [3:0] imm_for(op_e op, sel_e sel, logic [3:0] data);
    return ((sel == SelImm) && (op != OpClear)) ? data : 4'h0;
  endfunction

endpackage

// File: rtl/bus_step_timer.sv
// Loadable down-counter timing the SETUP and HOLD phases of a bus step.
//   clk_i      : clock
//   reset_i    : synchronous active-high reset
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : phase length minus one
//   dec_i      : count down while the phase is active (saturates at zero)
//   cnt_o      : current count
//   zero_o     : phase expires this cycle
module bus_step_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_xfer_seq.sv
// Command micro-sequencer for the lab bus datapath. Accepts one command per
// valid/ready handshake and expands it into bus-transfer steps, each made of
// SETUP (bus select driven), a one-cycle load STROBE, and HOLD.
//   clk, reset                      : clock, synchronous active-high reset
//   cmd_valid / cmd_ready           : command handshake (ready only when idle)
//   cmd_op, cmd_src, cmd_dst        : opcode, bus source, destination
//   cmd_data                        : immediate for LOAD / MOVE from IMM
//   bus_sel, imm_data               : datapath bus source and immediate value
//   ld_u2, ld_u3, ld_u4             : one-cycle register load strobes
//   busy, done, err                 : status; done/err pulse at completion
module bus_xfer_seq
  import bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_src,
  input  logic [1:0] cmd_dst,
  input  logic [3:0] cmd_data,
  output logic [1:0] bus_sel,
  output logic [3:0] imm_data,
  output logic       ld_u2,
  output logic       ld_u3,
  output logic       ld_u4,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned MaxCyc = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned TmrW   = $clog2(MaxCyc + 1);
  localparam logic [TmrW-1:0] SetupLoad = TmrW'(SETUP_CYC - 1);
  localparam logic [TmrW-1:0] HoldLoad  = TmrW'(HOLD_CYC - 1);

  state_e     state_d, state_q;
  op_e        op_d, op_q;
  sel_e       src_d, src_q;
  sel_e       dst_d, dst_q;
  logic [3:0] data_d, data_q;
  logic [1:0] step_d, step_q;
  sel_e       bus_sel_d, bus_sel_q;
  logic [3:0] imm_d, imm_q;
  logic [2:0] ld_d, ld_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;
  logic       err_d, err_q;

  logic            tmr_load, tmr_dec, tmr_zero;
  logic [TmrW-1:0] tmr_val, tmr_cnt;

  step_t acc_step, cur_step, nxt_step;
  op_e   in_op;
  sel_e  in_src, in_dst;

  assign in_op  = op_e'(cmd_op);
  assign in_src = sel_e'(cmd_src);
  assign in_dst = sel_e'(cmd_dst);

  assign acc_step = step_map(in_op, in_src, in_dst, 2'd0);
  assign cur_step = step_map(op_q, src_q, dst_q, step_q);
  assign nxt_step = step_map(op_q, src_q, dst_q, step_q + 2'd1);

  bus_step_timer #(
    .Width(TmrW)
  ) u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .cnt_o     (tmr_cnt),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    step_d    = step_q;
    bus_sel_d = bus_sel_q;
    imm_d     = imm_q;
    ld_d      = 3'b000;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = SetupLoad;
    tmr_dec   = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus_sel_d = SelImm;
        imm_d     = 4'h0;
        if (cmd_valid) begin
          op_d   = in_op;
          src_d  = in_src;
          dst_d  = in_dst;
          data_d = cmd_data;
          step_d = 2'd0;
          if (cmd_legal(in_op, in_src, in_dst)) begin
            state_d   = StSetup;
            tmr_load  = 1'b1;
            tmr_val   = SetupLoad;
            bus_sel_d = acc_step.sel;
            imm_d     = imm_for(in_op, acc_step.sel, cmd_data);
          end else begin
            state_d = StErr;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      StSetup: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          state_d = StStrobe;
          unique case (cur_step.dst)
            SelU2:   ld_d = 3'b001;
            SelU3:   ld_d = 3'b010;
            SelU4:   ld_d = 3'b100;
            default: ld_d = 3'b000;
          endcase
        end
      end
      StStrobe: begin
        state_d  = StHold;
        tmr_load = 1'b1;
        tmr_val  = HoldLoad;
        // done must be visible during the final HOLD cycle, so it is
        // registered one cycle ahead of that cycle.
        if (cur_step.last && (HOLD_CYC == 1)) begin
          done_d = 1'b1;
        end
      end
      StHold: begin
        tmr_dec = 1'b1;
        if (cur_step.last && (tmr_cnt == TmrW'(1))) begin
          done_d = 1'b1;
        end
        if (tmr_zero) begin
          if (cur_step.last) begin
            state_d   = StIdle;
            bus_sel_d = SelImm;
            imm_d     = 4'h0;
          end else begin
            state_d   = StSetup;
            step_d    = step_q + 2'd1;
            tmr_load  = 1'b1;
            tmr_val   = SetupLoad;
            bus_sel_d = nxt_step.sel;
            imm_d     = imm_for(op_q, nxt_step.sel, data_q);
          end
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OpLoad;
      src_q     <= SelImm;
      dst_q     <= SelImm;
      data_q    <= 4'h0;
      step_q    <= 2'd0;
      bus_sel_q <= SelImm;
      imm_q     <= 4'h0;
      ld_q      <= 3'b000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      step_q    <= step_d;
      bus_sel_q <= bus_sel_d;
      imm_q     <= imm_d;
      ld_q      <= ld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign bus_sel   = bus_sel_q;
  assign imm_data  = imm_q;
  assign ld_u2     = ld_q[0];
  assign ld_u3     = ld_q[1];
  assign ld_u4     = ld_q[2];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Bench for bus_xfer_seq: two instances (default timing and SETUP=3/HOLD=2)
// share one command stream. A reference model expands each accepted command
// into the expected per-cycle output frames and tracks register contents;
// a small register file driven by the DUT strobes stands in for the datapath.
module tb_bus_xfer_seq;

  localparam int unsigned S0 = 1;
  localparam int unsigned H0 = 1;
  localparam int unsigned S1 = 3;
  localparam int unsigned H1 = 2;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] imm;
    logic [2:0] ld;
    logic       busy;
    logic       done;
    logic       err;
    logic       wr;
    logic [1:0] wdst;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_src = 2'd0;
  logic [1:0] cmd_dst = 2'd0;
  logic [3:0] cmd_data = 4'h0;

  logic [1:0] rdy, busy, done, err;
  logic [1:0] sel0, sel1;
  logic [3:0] imm0, imm1;
  logic [2:0] ld0, ld1;
  logic [11:0] obs [2];
  logic [3:0]  bus_v [2];

  frame_t      fb [2][32];
  int unsigned fhead [2] = '{0, 0};
  int unsigned fcnt [2] = '{0, 0};
  logic [3:0]  mreg [2][4] = '{default: 4'h0};
  logic [3:0]  dreg [2][4] = '{default: 4'h0};
  bit          armed = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_xfer_seq #(.SETUP_CYC(S0), .HOLD_CYC(H0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .bus_sel(sel0), .imm_data(imm0), .ld_u2(ld0[0]), .ld_u3(ld0[1]), .ld_u4(ld0[2]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  bus_xfer_seq #(.SETUP_CYC(S1), .HOLD_CYC(H1)) dut_slow (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .bus_sel(sel1), .imm_data(imm1), .ld_u2(ld1[0]), .ld_u3(ld1[1]), .ld_u4(ld1[2]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  assign obs[0] = {sel0, imm0, ld0, busy[0], done[0], err[0]};
  assign obs[1] = {sel1, imm1, ld1, busy[1], done[1], err[1]};

  // Register file model driven by the DUT bus and strobes.
  always_comb begin
    bus_v[0] = (sel0 == 2'd0) ? imm0 : dreg[0][sel0];
    bus_v[1] = (sel1 == 2'd0) ? imm1 : dreg[1][sel1];
  end

  always @(posedge clk) begin
    for (int r = 1; r < 4; r++) begin
      if (ld0[r-1]) dreg[0][r] <= bus_v[0];
      if (ld1[r-1]) dreg[1][r] <= bus_v[1];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int k, input frame_t f);
    fb[k][(fhead[k] + fcnt[k]) % 32] = f;
    fcnt[k]++;
  endtask

  // Expand a command into expected output frames for cycles 1, 2, ...
  task automatic push_cmd(input int k, input logic [1:0] op, input logic [1:0] src,
                          input logic [1:0] dst, input logic [3:0] data);
    int unsigned s, l, n;
    logic [1:0] ssel [3];
    logic [1:0] sdst [3];
    logic [3:0] simm [3];
    logic [2:0] one;
    bit legal;
    frame_t f;
    s   = (k == 0) ? S0 : S1;
    l   = s + 1 + ((k == 0) ? H0 : H1);
    one = 3'b001;
    legal = (dst != 2'd0);
    if (op == 2'd2) begin
      legal = legal && (src == 2'd1 || src == 2'd2) && (dst == 2'd1 || dst == 2'd2)
              && (src != dst);
    end
    if (!legal) begin
      f = '0;
      f.busy = 1'b1;
      f.done = 1'b1;
      f.err  = 1'b1;
      push_frame(k, f);
      return;
    end
    n = 1;
    ssel[0] = 2'd0;
    simm[0] = 4'h0;
    sdst[0] = dst;
    case (op)
      2'd0: simm[0] = data;
      2'd1: begin
        ssel[0] = src;
        simm[0] = (src == 2'd0) ? data : 4'h0;
      end
      2'd2: begin
        n = 3;
        ssel[0] = src; sdst[0] = 2'd3; simm[0] = 4'h0;
        ssel[1] = dst; sdst[1] = src;  simm[1] = 4'h0;
        ssel[2] = 2'd3; sdst[2] = dst; simm[2] = 4'h0;
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = 1; j <= l; j++) begin
        f      = '0;
        f.sel  = ssel[i];
        f.imm  = simm[i];
        f.ld   = (j == s + 1) ? (one << (sdst[i] - 2'd1)) : 3'b000;
        f.busy = 1'b1;
        f.done = (i == n - 1) && (j == l);
        f.wr   = (j == s + 1);
        f.wdst = sdst[i];
        push_frame(k, f);
      end
    end
  endtask

  // One cycle of the reference model for instance k, evaluated mid-cycle.
  task automatic model_cycle(input int k);
    frame_t e;
    logic [11:0] got, exp;
    bit idle;
    idle = (fcnt[k] == 0);
    e = idle ? '0 : fb[k][fhead[k]];
    got = obs[k];
    // The immediate is only meaningful while the bus is sourced from it.
    if (e.sel != 2'd0) got[9:6] = 4'h0;
    exp = {e.sel, e.imm, e.ld, e.busy, e.done, e.err};
    check_eq($sformatf("frame%0d", k), 32'(got), 32'(exp));
    check_eq($sformatf("ready%0d", k), 32'(rdy[k]), 32'(idle && !reset));
    if (idle) begin
      for (int r = 1; r < 4; r++) begin
        check_eq($sformatf("reg%0d_u%0d", k, r + 1), 32'(dreg[k][r]), 32'(mreg[k][r]));
      end
    end else begin
      if (e.wr) mreg[k][e.wdst] = (e.sel == 2'd0) ? e.imm : mreg[k][e.sel];
      fhead[k] = (fhead[k] + 1) % 32;
      fcnt[k]--;
    end
    if (reset) begin
      fcnt[k] = 0;
    end else if (cmd_valid && idle) begin
      push_cmd(k, cmd_op, cmd_src, cmd_dst, cmd_data);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      model_cycle(0);
      model_cycle(1);
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((fcnt[0] != 0 || fcnt[1] != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("wait_idle", 32'(t < 100), 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [3:0] data, input int hold);
    wait_idle();
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_data  = data;
    cmd_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1 armed = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    issue(2'd0, 2'd0, 2'd1, 4'b1010, 1);  // LOAD U2 = 1010
    issue(2'd0, 2'd0, 2'd2, 4'b0111, 1);  // LOAD U3 = 0111
    issue(2'd1, 2'd1, 2'd3, 4'h5, 1);     // MOVE U2 -> U4
    wait_idle();
    check_eq("u4_after_move", 32'(dreg[0][3]), 32'h0a);
    issue(2'd2, 2'd1, 2'd2, 4'h0, 1);     // SWAP U2, U3
    wait_idle();
    check_eq("u2_after_swap", 32'(dreg[0][1]), 32'h07);
    check_eq("u3_after_swap", 32'(dreg[0][2]), 32'h0a);
    check_eq("u2_after_swap_slow", 32'(dreg[1][1]), 32'h07);
    issue(2'd1, 2'd1, 2'd0, 4'h3, 1);     // illegal: dst = 00
    issue(2'd2, 2'd3, 2'd1, 4'h3, 1);     // illegal: SWAP from U4
    issue(2'd1, 2'd0, 2'd2, 4'hc, 1);     // MOVE IMM -> U3

    // Reset during cycle 4 of a SWAP.
    issue(2'd2, 2'd1, 2'd2, 4'h0, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    // CLEAR with valid held high; each instance may accept only when ready.
    issue(2'd3, 2'd2, 2'd2, 4'hf, 7);
    issue(2'd0, 2'd0, 2'd3, 4'h9, 1);

    // Random stream, including commands offered while busy and rare resets.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_src   = 2'($urandom_range(0, 3));
      cmd_dst   = 2'($urandom_range(0, 3));
      cmd_data  = 4'($urandom_range(0, 15));
      reset     = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    reset     = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
